// File: rtl/bus_txn_tracker.sv
// Passive multi-channel request/response tap: pairs each response with the oldest
// outstanding request per channel and reports address, data, latency and protocol errors.
module bus_txn_tracker #(
  parameter int N_CH       = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 1000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic [N_CH-1:0]                     req_valid,
  input  logic [N_CH-1:0]                     req_ready,
  input  logic [N_CH*ADDR_WIDTH-1:0]          req_addr,
  input  logic [N_CH-1:0]                     rsp_valid,
  input  logic [N_CH-1:0]                     rsp_ready,
  input  logic [N_CH*DATA_WIDTH-1:0]          rsp_data,
  output logic [N_CH-1:0]                     evt_valid,
  output logic [N_CH*ADDR_WIDTH-1:0]          evt_addr,
  output logic [N_CH*DATA_WIDTH-1:0]          evt_data,
  output logic [N_CH*CNT_WIDTH-1:0]           evt_latency,
  output logic [N_CH*($clog2(DEPTH)+1)-1:0]   outstanding,
  output logic [N_CH*CNT_WIDTH-1:0]           txn_count,
  output logic [N_CH-1:0]                     err_overflow,
  output logic [N_CH-1:0]                     err_underflow,
  output logic [N_CH-1:0]                     err_timeout
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

  logic [CNT_WIDTH-1:0] now_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) now_reg <= '0;
    else      now_reg <= now_reg + 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [ADDR_WIDTH-1:0] addr_mem  [DEPTH];
      logic [CNT_WIDTH-1:0]  stamp_mem [DEPTH];
      logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
      logic [OW-1:0]         occ_reg;
      logic                  evt_valid_reg;
      logic [ADDR_WIDTH-1:0] evt_addr_reg;
      logic [DATA_WIDTH-1:0] evt_data_reg;
      logic [CNT_WIDTH-1:0]  evt_latency_reg;
      logic [CNT_WIDTH-1:0]  txn_count_reg;
      logic                  err_overflow_reg, err_underflow_reg, err_timeout_reg;
      logic                  push, pop, empty, full, do_push, do_pop;
      logic                  overflow, underflow, timed_out;
      logic [CNT_WIDTH-1:0]  age;

      assign push      = req_valid[gi] & req_ready[gi];
      assign pop       = rsp_valid[gi] & rsp_ready[gi];
      assign empty     = (occ_reg == '0);
      assign full      = (occ_reg == OW'(DEPTH));
      assign do_pop    = pop & ~empty;
      assign do_push   = push & (~full | do_pop);
      assign overflow  = push & full & ~do_pop;
      assign underflow = pop & empty;
      // Head is read combinationally so its age can be watched every cycle.
      assign age       = now_reg - stamp_mem[rd_ptr_reg];
      assign timed_out = (TIMEOUT_C != '0) && !empty && (age >= TIMEOUT_C);

      always_ff @(posedge clk) begin
        if (do_push) begin
          addr_mem[wr_ptr_reg]  <= req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
          stamp_mem[wr_ptr_reg] <= now_reg;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wr_ptr_reg        <= '0;
          rd_ptr_reg        <= '0;
          occ_reg           <= '0;
          evt_valid_reg     <= 1'b0;
          evt_addr_reg      <= '0;
          evt_data_reg      <= '0;
          evt_latency_reg   <= '0;
          txn_count_reg     <= '0;
          err_overflow_reg  <= 1'b0;
          err_underflow_reg <= 1'b0;
          err_timeout_reg   <= 1'b0;
        end else begin
          if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
          if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
          occ_reg       <= occ_reg + OW'(do_push) - OW'(do_pop);
          evt_valid_reg <= do_pop;
          if (do_pop) begin
            evt_addr_reg    <= addr_mem[rd_ptr_reg];
            evt_data_reg    <= rsp_data[gi*DATA_WIDTH +: DATA_WIDTH];
            evt_latency_reg <= age;
          end
          // clear wins over any same-cycle increment or error
          if (clear) begin
            txn_count_reg     <= '0;
            err_overflow_reg  <= 1'b0;
            err_underflow_reg <= 1'b0;
            err_timeout_reg   <= 1'b0;
          end else begin
            if (do_pop && !(&txn_count_reg)) txn_count_reg <= txn_count_reg + 1'b1;
            if (overflow)  err_overflow_reg  <= 1'b1;
            if (underflow) err_underflow_reg <= 1'b1;
            if (timed_out) err_timeout_reg   <= 1'b1;
          end
        end
      end

      assign evt_valid[gi]                             = evt_valid_reg;
      assign evt_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]     = evt_addr_reg;
      assign evt_data[gi*DATA_WIDTH +: DATA_WIDTH]     = evt_data_reg;
      assign evt_latency[gi*CNT_WIDTH +: CNT_WIDTH]    = evt_latency_reg;
      assign outstanding[gi*OW +: OW]                  = occ_reg;
      assign txn_count[gi*CNT_WIDTH +: CNT_WIDTH]      = txn_count_reg;
      assign err_overflow[gi]                          = err_overflow_reg;
      assign err_underflow[gi]                         = err_underflow_reg;
      assign err_timeout[gi]                           = err_timeout_reg;
    end
  endgenerate

endmodule
